axil_reg_bridge: RTL

AXIL_REG_BRIDGE -- requirements
Module: axil_reg_bridge

---
 rtl/axil_reg_bridge.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/axil_reg_bridge.sv
// rtl/axil_reg_bridge.sv - AXI4-Lite slave to one-cycle register write/read strobe bridge
// Optional macro AXIL_REG_BRIDGE_CNT_EN adds B/R handshake counters o_wr_cnt/o_rd_cnt.
module axil_reg_bridge #(
  parameter int REG_ADDR_WIDTH = 16,
  parameter int REG_DATA_WIDTH = 64,
  parameter int RD_LATENCY     = 1
) (
  input  logic                          ps_clk,
  input  logic                          ps_rst,
`ifdef AXIL_REG_BRIDGE_CNT_EN
  output logic [31:0]                   o_wr_cnt,
  output logic [31:0]                   o_rd_cnt,
`endif
  input  logic [REG_ADDR_WIDTH-1:0]     s_axil_awaddr,
  input  logic                          s_axil_awvalid,
  output logic                          s_axil_awready,
  input  logic [REG_DATA_WIDTH-1:0]     s_axil_wdata,
  input  logic [REG_DATA_WIDTH/8-1:0]   s_axil_wstrb,
  input  logic                          s_axil_wvalid,
  output logic                          s_axil_wready,
  output logic [1:0]                    s_axil_bresp,
  output logic                          s_axil_bvalid,
  input  logic                          s_axil_bready,
  input  logic [REG_ADDR_WIDTH-1:0]     s_axil_araddr,
  input  logic                          s_axil_arvalid,
  output logic                          s_axil_arready,
  output logic [REG_DATA_WIDTH-1:0]     s_axil_rdata,
  output logic [1:0]                    s_axil_rresp,
  output logic                          s_axil_rvalid,
  input  logic                          s_axil_rready,
  output logic                          o_reg_wen,
  output logic [REG_ADDR_WIDTH-1:0]     o_reg_waddr,
  output logic [REG_DATA_WIDTH-1:0]     o_reg_wdata,
  output logic                          o_reg_ren,
  output logic [REG_ADDR_WIDTH-1:0]     o_reg_raddr,
  input  logic [REG_DATA_WIDTH-1:0]     i_reg_rdata
);

  localparam int         STRB_WIDTH = REG_DATA_WIDTH / 8;
  localparam logic [2:0] RD_LAST    = 3'(RD_LATENCY);

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

  w_state_t               w_state, w_state_nxt;
  r_state_t               r_state, r_state_nxt;
  logic                   aw_got, w_got;
  logic                   aw_hs, w_hs, ar_hs;
  logic                   w_err, r_err;
  logic [STRB_WIDTH-1:0]  wstrb_q;
  logic [2:0]             r_cnt;

  // Only full-width, 8-byte-aligned accesses reach the register file.
  assign w_err = (o_reg_waddr[2:0] != 3'd0) || (wstrb_q != {STRB_WIDTH{1'b1}});
  assign r_err = (o_reg_raddr[2:0] != 3'd0);

  always_comb begin
    w_state_nxt    = w_state;
    s_axil_awready = 1'b0;
    s_axil_wready  = 1'b0;
    s_axil_bvalid  = 1'b0;
    o_reg_wen      = 1'b0;
    aw_hs          = 1'b0;
    w_hs           = 1'b0;
    if (!ps_rst) begin
      case (w_state)
        W_IDLE: begin
          s_axil_awready = !aw_got;
          s_axil_wready  = !w_got;
          aw_hs          = s_axil_awvalid && !aw_got;
          w_hs           = s_axil_wvalid && !w_got;
          if ((aw_got || aw_hs) && (w_got || w_hs))
            w_state_nxt = W_EXEC;
        end
        W_EXEC: begin
          o_reg_wen   = !w_err;
          w_state_nxt = W_RESP;
        end
        W_RESP: begin
          s_axil_bvalid = 1'b1;
          if (s_axil_bready)
            w_state_nxt = W_IDLE;
        end
        default: w_state_nxt = W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ps_clk) begin
    if (ps_rst) begin
      w_state      <= W_IDLE;
      aw_got       <= 1'b0;
      w_got        <= 1'b0;
      o_reg_waddr  <= '0;
      o_reg_wdata  <= '0;
      wstrb_q      <= '0;
      s_axil_bresp <= 2'b00;
    end else begin
      w_state <= w_state_nxt;
      if (aw_hs) begin
        aw_got      <= 1'b1;
        o_reg_waddr <= s_axil_awaddr;
      end
      if (w_hs) begin
        w_got       <= 1'b1;
        o_reg_wdata <= s_axil_wdata;
        wstrb_q     <= s_axil_wstrb;
      end
      if (w_state == W_EXEC) begin
        aw_got       <= 1'b0;
        w_got        <= 1'b0;
        s_axil_bresp <= w_err ? 2'b10 : 2'b00;
      end
    end
  end

  always_comb begin
    r_state_nxt    = r_state;
    s_axil_arready = 1'b0;
    s_axil_rvalid  = 1'b0;
    o_reg_ren      = 1'b0;
    ar_hs          = 1'b0;
    if (!ps_rst) begin
      case (r_state)
        R_IDLE: begin
          s_axil_arready = 1'b1;
          ar_hs          = s_axil_arvalid;
          if (s_axil_arvalid)
            r_state_nxt = R_WAIT;
        end
        R_WAIT: begin
          o_reg_ren = (r_cnt == 3'd0) && !r_err;
          if (r_cnt == RD_LAST)
            r_state_nxt = R_RESP;
        end
        R_RESP: begin
          s_axil_rvalid = 1'b1;
          if (s_axil_rready)
            r_state_nxt = R_IDLE;
        end
        default: r_state_nxt = R_IDLE;
      endcase
    end
  end

  // R_WAIT spans RD_LATENCY+1 cycles; read data is captured on its final edge.
  always_ff @(posedge ps_clk) begin
    if (ps_rst) begin
      r_state      <= R_IDLE;
      r_cnt        <= 3'd0;
      o_reg_raddr  <= '0;
      s_axil_rdata <= '0;
      s_axil_rresp <= 2'b00;
    end else begin
      r_state <= r_state_nxt;
      if (ar_hs) begin
        o_reg_raddr <= s_axil_araddr;
        r_cnt       <= 3'd0;
      end
      if (r_state == R_WAIT) begin
        r_cnt <= r_cnt + 3'd1;
        if (r_cnt == RD_LAST) begin
          s_axil_rdata <= r_err ? '0 : i_reg_rdata;
          s_axil_rresp <= r_err ? 2'b10 : 2'b00;
        end
      end
    end
  end

`ifdef AXIL_REG_BRIDGE_CNT_EN
  logic b_hs, r_hs;
  assign b_hs = s_axil_bvalid && s_axil_bready;
  assign r_hs = s_axil_rvalid && s_axil_rready;

  always_ff @(posedge ps_clk) begin
    if (ps_rst) begin
      o_wr_cnt <= 32'd0;
      o_rd_cnt <= 32'd0;
    end else begin
      if (b_hs) o_wr_cnt <= o_wr_cnt + 32'd1;
      if (r_hs) o_rd_cnt <= o_rd_cnt + 32'd1;
    end
  end
`endif

endmodule
